// File: rtl/bldc_encoder_sampler.sv
// Periodic sampler for a free-running quadrature count: reports the signed count
// change over each SAMPLE_PERIOD-clock window and accumulates it until the host acknowledges.
module bldc_encoder_sampler #(
  parameter int COUNTER_WIDTH = 15,
  parameter int PERIOD_WIDTH  = 16,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] count,
  input  logic                     ack,
  output logic [COUNTER_WIDTH-1:0] delta,
  output logic                     delta_valid,
  output logic                     overrun,
  output logic [7:0]               seq
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [PERIOD_WIDTH-1:0] TIMER_LAST = PERIOD_WIDTH'(SAMPLE_PERIOD - 1);

  state_e                   state_q, state_d;
  logic [PERIOD_WIDTH-1:0]  timer_q, timer_d;
  logic [COUNTER_WIDTH-1:0] prev_q, prev_d;
  logic [COUNTER_WIDTH-1:0] delta_q, delta_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic [7:0]               seq_q, seq_d;
  logic                     close;
  logic [COUNTER_WIDTH-1:0] win_d;

  // Unsigned subtraction wraps naturally, giving the signed delta across 0x7FFF/0x0000.
  assign win_d = count - prev_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    prev_d    = prev_q;
    delta_d   = delta_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    seq_d     = seq_q;
    close     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          prev_d  = count;
          timer_d = '0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          close   = 1'b1;
          timer_d = '0;
          prev_d  = count;
          seq_d   = seq_q + 8'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An ack coinciding with a close consumes the old sample and replaces it outright.
    if (close) begin
      if (!valid_q || ack) begin
        delta_d   = win_d;
        valid_d   = 1'b1;
        overrun_d = 1'b0;
      end else begin
        delta_d   = delta_q + win_d;
        overrun_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      prev_q    <= '0;
      delta_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      prev_q    <= prev_d;
      delta_q   <= delta_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      seq_q     <= seq_d;
    end
  end

  assign delta       = delta_q;
  assign delta_valid = valid_q;
  assign overrun     = overrun_q;
  assign seq         = seq_q;

endmodule

// File: tb/tb_bldc_encoder_sampler.sv
// Scoreboard bench for bldc_encoder_sampler with SAMPLE_PERIOD=4: stimulus queues the
// expected sample for every window close, a monitor compares when seq advances.
module tb_bldc_encoder_sampler;

  localparam int CW = 15;
  localparam int P  = 4;

  typedef struct {
    logic [CW-1:0] delta;
    logic          ovr;
    logic [7:0]    seq;
  } exp_t;

  logic          clk, reset, enable, ack;
  logic [CW-1:0] count, delta;
  logic          delta_valid, overrun;
  logic [7:0]    seq;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [7:0]    exp_seq  = 8'd0;
  logic [7:0]    last_seq = 8'd0;
  logic [CW-1:0] held_delta = '0;

  bldc_encoder_sampler #(
    .COUNTER_WIDTH(CW),
    .PERIOD_WIDTH (16),
    .SAMPLE_PERIOD(P)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .count      (count),
    .ack        (ack),
    .delta      (delta),
    .delta_valid(delta_valid),
    .overrun    (overrun),
    .seq        (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every seq advance is a presented sample; compare against the head of the queue.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      last_seq = 8'd0;
    end else if (seq !== last_seq) begin
      last_seq = seq;
      check("mon_queue_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_delta", delta, e.delta);
        check("mon_valid", delta_valid, 1'b1);
        check("mon_overrun", overrun, e.ovr);
        check("mon_seq", seq, e.seq);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts right after an entry or closing edge (timer=0); ends right after the next close.
  task automatic run_window(input logic [CW-1:0] end_count, input logic ack_first,
                            input logic ack_close, input logic [CW-1:0] exp_delta,
                            input logic exp_ovr);
    ack = ack_first;
    step();
    ack = 1'b0;
    if (ack_first) begin
      check("ack_clears_valid", delta_valid, 1'b0);
      check("ack_clears_overrun", overrun, 1'b0);
      check("ack_holds_delta", delta, held_delta);
    end
    repeat (P - 2) step();
    check("no_early_close", seq, exp_seq);
    count   = end_count;
    ack     = ack_close;
    exp_seq = exp_seq + 8'd1;
    exp_q.push_back('{delta: exp_delta, ovr: exp_ovr, seq: exp_seq});
    step();
    ack        = 1'b0;
    held_delta = exp_delta;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    ack    = 1'b0;
    count  = '0;
    #2;
    check("rst_delta", delta, 0);
    check("rst_valid", delta_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_seq", seq, 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();

    // Basic window: enter at 100, close at 110.
    count  = 15'd100;
    enable = 1'b1;
    step();
    run_window(15'd110, 1'b0, 1'b0, 15'd10, 1'b0);

    // Wrap in both directions, acking each prior sample early in the window.
    run_window(15'h7FFE, 1'b1, 1'b0, 15'h7F90, 1'b0);
    run_window(15'h0003, 1'b1, 1'b0, 15'd5,    1'b0);
    run_window(15'h0002, 1'b1, 1'b0, 15'h7FFF, 1'b0);
    run_window(15'h7FFD, 1'b1, 1'b0, 15'h7FFB, 1'b0);

    // Unacked windows accumulate: +7 then -2 -> 5 with sticky overrun.
    run_window(15'h0004, 1'b1, 1'b0, 15'd7, 1'b0);
    run_window(15'h0002, 1'b0, 1'b0, 15'd5, 1'b1);

    // Ack clears the overrun; then ack on the closing edge replaces pending 3 with 9.
    run_window(15'h0005, 1'b1, 1'b0, 15'd3, 1'b0);
    run_window(15'h000E, 1'b0, 1'b1, 15'd9, 1'b0);

    // Leave RUN mid-window, move the count by 50 while idle, ack in IDLE, re-enter.
    step();
    enable = 1'b0;
    step();
    count = 15'h000E + 15'd50;
    ack   = 1'b1;
    step();
    ack = 1'b0;
    check("idle_ack_valid", delta_valid, 1'b0);
    check("idle_ack_delta", delta, 15'd9);
    step();
    enable = 1'b1;
    step();
    run_window(15'h0044, 1'b0, 1'b0, 15'd4, 1'b0);
    run_window(15'h0045, 1'b1, 1'b0, 15'd1, 1'b0);
    run_window(15'h0047, 1'b1, 1'b0, 15'd2, 1'b0);

    // Async reset between edges with a pending sample and seq=12.
    @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_seq", seq, 8'd12);
    check("pre_rst_valid", delta_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_delta", delta, 0);
    check("async_rst_valid", delta_valid, 0);
    check("async_rst_overrun", overrun, 0);
    check("async_rst_seq", seq, 0);
    reset   = 1'b0;
    exp_seq = 8'd0;

    // Enable already high: RUN entry on the first edge, no partial window reported.
    step();
    run_window(15'h0050, 1'b0, 1'b0, 15'd9, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
